mcs6530_bus_arbiter: RTL and testbench
======================================

# mcs6530_bus_arbiter

Shares the single bus port of one `mcs6530` instance between the 6502 CPU and a host/debug requester, such as a loader that fills RAM or a monitor that peeks I/O and timer registers. Each phi2 cycle it issues at most one access, steers the registered read data back to the requester that issued it, and stalls the CPU through a RDY-style signal when the host has waited too long. It sits directly between the CPU bus decode and the `mcs6530` port pins.

## Interface
Parameters:
- `STARVE_LIMIT`, default 15: number of cycles the host may wait before it is forcibly granted. 0 gives the host strict priority.
- `WAIT_W`, default 4: width of the host wait counter. Must satisfy `STARVE_LIMIT` < 2^`WAIT_W`.

Ports:
- `phi2` input 1: the only clock. All state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `cpu_req` input 1: CPU access is present this cycle.
- `cpu_we_n`, `cpu_rs0`, `cpu_cs1` input 1 each: CPU access attributes.
- `cpu_a` input 10 / `cpu_di` input 8: CPU address and write data.
- `cpu_rdy` output 1: when 0, the CPU access is not taken and the CPU must hold it.
- `cpu_do` output 8 / `cpu_do_valid` output 1: CPU read data, and its one-cycle valid pulse.
- `host_req`, `host_we_n`, `host_rs0`, `host_cs1` input 1 each; `host_a` input 10; `host_di` input 8: host access. Must stay stable until `host_ack`.
- `host_ack` output 1: one-cycle pulse in the cycle the host access is issued.
- `host_rdata` output 8 / `host_rvalid` output 1 / `host_rerr` output 1: host read result. `host_rerr` = the sampled `mcs_oe` was 0 (unmapped address).
- `mcs_we_n`, `mcs_rs0`, `mcs_cs1` output 1 each; `mcs_a` output 10; `mcs_di` output 8: drive the 6530.
- `mcs_do` input 8 / `mcs_oe` input 1: 6530 read data. Valid one phi2 cycle after the access is issued.

## Operation
- The grant decision is combinational from the current requests, `wait_cnt`, and `rst`. The `mcs_*` outputs are a combinational mux of the granted requester.
- Idle bus, when nothing is granted or `rst`=1: `mcs_rs0`=1, `mcs_cs1`=1, `mcs_we_n`=1, `mcs_a`=0, `mcs_di`=0. This deselects ROM, RAM, I/O and timer.
- Priority:
  - `force` = `host_req` & (`wait_cnt` == `STARVE_LIMIT`).
  - If `force`: the host is granted, `host_ack`=1, and `cpu_rdy`=0.
  - Else if `cpu_req`: the CPU is granted and `cpu_rdy`=1.
  - Else if `host_req`: the host is granted.
- `cpu_rdy`=1 whenever there is no `force` and `rst`=0, regardless of `cpu_req`.
- `wait_cnt` register:
  - Cleared when `host_req`=0 or when the host is granted.
  - Otherwise incremented, saturating at `STARVE_LIMIT`.
  - After a forced grant the counter restarts from 0, so a continuously requesting host gets at most one slot every `STARVE_LIMIT`+1 cycles while the CPU is busy.
- Response tag register, loaded every cycle: `{pend_valid, pend_owner}`.
  - `pend_valid` = (a read was granted).
  - `pend_owner` = host or CPU.
  - Writes produce no response.
- Response cycle (issue+1):
  - If `pend_valid` and the owner is the CPU: `cpu_do`=`mcs_do`, `cpu_do_valid`=1.
  - If `pend_valid` and the owner is the host: `host_rdata`=`mcs_do`, `host_rvalid`=1, `host_rerr`=~`mcs_oe`.
  - `cpu_do` and `host_rdata` are registered captures and hold their last value between pulses. They are 0 after reset.
- Back-to-back accesses from alternating requesters pipeline with no bubble: an issue and the previous response happen in the same cycle.

## Timing
- Reset: while `rst`=1 and in the cycle it is sampled:
  - `wait_cnt`=0 and `pend_valid`=0.
  - `cpu_do`=0, `host_rdata`=0.
  - `cpu_do_valid`, `host_rvalid`, `host_rerr`, `host_ack` = 0.
  - `cpu_rdy`=0 and the bus is idle.
- Reset mid-operation: a read issued in the cycle before `rst` rises produces no valid pulse.
- Latencies:
  - Grant to bus: 0 cycles.
  - Read issue to `*_valid`: 1 cycle.
  - `host_req` with the CPU continuously busy to `host_ack`: exactly `STARVE_LIMIT` cycles after `host_req` first rises. The ack falls in cycle `STARVE_LIMIT`, counting from 0.
- Simultaneous `cpu_req` and `host_req`, no force: the CPU wins and `wait_cnt` increments.
- With `STARVE_LIMIT`=0: the host always wins, on its first cycle.
- `host_req` that drops before ack: the counter clears and nothing is issued.

## Test plan
- CPU RAM write/read: write `cpu_a`=0x3C5, `rs0`=1, `cs1`=0, `di`=0xA5, then read the same address. Required: `cpu_do`=0xA5 with `cpu_do_valid`=1 exactly one cycle after the read issue, and `cpu_rdy`=1 throughout.
- Host-only access with the CPU idle: host reads the I/O register at 0x340. Required: `host_ack` in cycle 0, `host_rvalid`=1 in cycle 1, `host_rerr`=0. Host reads the unmapped address 0x000 with `rs0`=1, `cs1`=0. Required: `host_rvalid`=1 and `host_rerr`=1.
- Starvation with `STARVE_LIMIT`=15: `cpu_req` held at 1 continuously and `host_req` raised at cycle 0. Required:
  - `host_ack` and `cpu_rdy`=0 only in cycle 15.
  - The next `host_ack` at cycle 31.
  - The CPU is granted in every other cycle.
- Alternating owners: CPU read of 0x3C0, then host read of 0x3C1 in the next cycle, with RAM preloaded to 0x11 and 0x22. Required: `cpu_do`=0x11 in cycle 1 and `host_rdata`=0x22 in cycle 2. There must be no cross-routing.
- Reset mid-read: host read issued in cycle 0 and `rst`=1 in cycle 1. Required:
  - No `host_rvalid`.
  - Bus idle (`mcs_rs0`=1, `mcs_cs1`=1).
  - `cpu_rdy`=0.
  - `wait_cnt` restarts from 0 after reset.
- `host_req` withdrawn at cycle 5 while the CPU is busy, then reasserted. Required: the forced ack occurs 15 cycles after the reassert, not earlier.

Source files
------------

// File: rtl/mcs6530_bus_arbiter_if.sv
// Bus bundle between the CPU/host requesters, the arbiter and one mcs6530 port.
// The arbiter takes the slave view; the requesters and the chip model take the master view.
interface mcs6530_bus_arbiter_if;
  logic       cpu_req, cpu_we_n, cpu_rs0, cpu_cs1;
  logic [9:0] cpu_a;
  logic [7:0] cpu_di;
  logic       cpu_rdy;
  logic [7:0] cpu_do;
  logic       cpu_do_valid;

  logic       host_req, host_we_n, host_rs0, host_cs1;
  logic [9:0] host_a;
  logic [7:0] host_di;
  logic       host_ack;
  logic [7:0] host_rdata;
  logic       host_rvalid, host_rerr;

  logic       mcs_we_n, mcs_rs0, mcs_cs1;
  logic [9:0] mcs_a;
  logic [7:0] mcs_di;
  logic [7:0] mcs_do;
  logic       mcs_oe;

  modport slave (
    input  cpu_req, cpu_we_n, cpu_rs0, cpu_cs1, cpu_a, cpu_di,
    output cpu_rdy, cpu_do, cpu_do_valid,
    input  host_req, host_we_n, host_rs0, host_cs1, host_a, host_di,
    output host_ack, host_rdata, host_rvalid, host_rerr,
    output mcs_we_n, mcs_rs0, mcs_cs1, mcs_a, mcs_di,
    input  mcs_do, mcs_oe
  );

  modport master (
    output cpu_req, cpu_we_n, cpu_rs0, cpu_cs1, cpu_a, cpu_di,
    input  cpu_rdy, cpu_do, cpu_do_valid,
    output host_req, host_we_n, host_rs0, host_cs1, host_a, host_di,
    input  host_ack, host_rdata, host_rvalid, host_rerr,
    input  mcs_we_n, mcs_rs0, mcs_cs1, mcs_a, mcs_di,
    output mcs_do, mcs_oe
  );
endinterface

// File: rtl/mcs6530_bus_arbiter.sv
// Shares one mcs6530 bus port between the 6502 and a host/debug requester:
// CPU-first priority with a starvation-forced host slot, tagged read-response steering.
module mcs6530_bus_arbiter #(
  parameter int STARVE_LIMIT = 15,
  parameter int WAIT_W       = 4
) (
  input  logic                  phi2,
  input  logic                  rst,
  mcs6530_bus_arbiter_if.slave  bus
);
  typedef struct packed {
    logic       we_n;
    logic       rs0;
    logic       cs1;
    logic [9:0] a;
    logic [7:0] di;
  } acc_t;

  // rs0=1/cs1=1 with no write deselects ROM, RAM, I/O and timer
  localparam acc_t IDLE = '{we_n: 1'b1, rs0: 1'b1, cs1: 1'b1, a: 10'h000, di: 8'h00};
  localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(STARVE_LIMIT);

  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              pend_valid_q, pend_valid_d;
  logic              pend_host_q, pend_host_d;
  logic [7:0]        cpu_do_q, cpu_do_d;
  logic [7:0]        host_rdata_q, host_rdata_d;

  logic force_gnt, gnt_cpu, gnt_host, rsp_cpu, rsp_host;
  acc_t cpu_acc, host_acc, bus_acc;

  assign cpu_acc  = '{we_n: bus.cpu_we_n, rs0: bus.cpu_rs0, cs1: bus.cpu_cs1,
                      a: bus.cpu_a, di: bus.cpu_di};
  assign host_acc = '{we_n: bus.host_we_n, rs0: bus.host_rs0, cs1: bus.host_cs1,
                      a: bus.host_a, di: bus.host_di};

  always_comb begin
    force_gnt = ~rst & bus.host_req & (wait_q == LIMIT);
    gnt_host  = ~rst & (force_gnt | (~bus.cpu_req & bus.host_req));
    gnt_cpu   = ~rst & ~force_gnt & bus.cpu_req;

    bus_acc = IDLE;
    if (gnt_host)     bus_acc = host_acc;
    else if (gnt_cpu) bus_acc = cpu_acc;

    // A waiting host only accumulates while it keeps asking and keeps losing
    wait_d = wait_q;
    if (rst || !bus.host_req || gnt_host) wait_d = '0;
    else if (wait_q != LIMIT)             wait_d = wait_q + 1'b1;

    pend_valid_d = (gnt_host & bus.host_we_n) | (gnt_cpu & bus.cpu_we_n);
    pend_host_d  = gnt_host;

    // The chip's read data lands one cycle after issue; show it live, hold it after
    rsp_cpu  = ~rst & pend_valid_q & ~pend_host_q;
    rsp_host = ~rst & pend_valid_q &  pend_host_q;

    cpu_do_d     = rsp_cpu  ? bus.mcs_do : cpu_do_q;
    host_rdata_d = rsp_host ? bus.mcs_do : host_rdata_q;
  end

  always_ff @(posedge phi2) begin
    if (rst) begin
      wait_q       <= '0;
      pend_valid_q <= 1'b0;
      pend_host_q  <= 1'b0;
      cpu_do_q     <= 8'h00;
      host_rdata_q <= 8'h00;
    end else begin
      wait_q       <= wait_d;
      pend_valid_q <= pend_valid_d;
      pend_host_q  <= pend_host_d;
      cpu_do_q     <= cpu_do_d;
      host_rdata_q <= host_rdata_d;
    end
  end

  assign bus.mcs_we_n     = bus_acc.we_n;
  assign bus.mcs_rs0      = bus_acc.rs0;
  assign bus.mcs_cs1      = bus_acc.cs1;
  assign bus.mcs_a        = bus_acc.a;
  assign bus.mcs_di       = bus_acc.di;

  assign bus.cpu_rdy      = ~rst & ~force_gnt;
  assign bus.cpu_do       = rst ? 8'h00 : cpu_do_d;
  assign bus.cpu_do_valid = rsp_cpu;

  assign bus.host_ack     = gnt_host;
  assign bus.host_rdata   = rst ? 8'h00 : host_rdata_d;
  assign bus.host_rvalid  = rsp_host;
  assign bus.host_rerr    = rsp_host & ~bus.mcs_oe;
endmodule

// File: tb/tb_mcs6530_bus_arbiter.sv
// Bench for mcs6530_bus_arbiter: grant vectors, a small 6530 memory model and a
// cycle-tagged response scoreboard, plus starvation and reset corner sequences.
module tb_mcs6530_bus_arbiter;
  logic phi2 = 1'b0;
  logic rst  = 1'b1;
  int   cyc  = 0;
  int   total_cnt = 0;
  int   pass_cnt  = 0;

  always #5 phi2 = ~phi2;
  always @(posedge phi2) cyc <= cyc + 1;

  mcs6530_bus_arbiter_if ifa ();
  mcs6530_bus_arbiter_if ifb ();

  mcs6530_bus_arbiter #(.STARVE_LIMIT(15), .WAIT_W(4)) dut (.phi2(phi2), .rst(rst), .bus(ifa));
  mcs6530_bus_arbiter #(.STARVE_LIMIT(0),  .WAIT_W(1)) dut0 (.phi2(phi2), .rst(rst), .bus(ifb));

  assign ifb.mcs_do = 8'h00;
  assign ifb.mcs_oe = 1'b0;

  // 6530 stand-in: ROM (rs0=0), 64-byte RAM at 0x3C0, I/O at 0x340; registered read data
  logic [7:0] ram [64];
  always @(posedge phi2) begin
    ifa.mcs_oe <= 1'b0;
    ifa.mcs_do <= 8'h00;
    if (!ifa.mcs_cs1) begin
      if (!ifa.mcs_rs0) begin
        if (ifa.mcs_we_n) begin
          ifa.mcs_oe <= 1'b1;
          ifa.mcs_do <= ifa.mcs_a[7:0] ^ 8'h5A;
        end
      end else if (ifa.mcs_a[9:6] == 4'hF) begin
        if (ifa.mcs_we_n) begin
          ifa.mcs_oe <= 1'b1;
          ifa.mcs_do <= ram[ifa.mcs_a[5:0]];
        end else begin
          ram[ifa.mcs_a[5:0]] <= ifa.mcs_di;
        end
      end else if (ifa.mcs_a[9:6] == 4'hD) begin
        if (ifa.mcs_we_n) begin
          ifa.mcs_oe <= 1'b1;
          ifa.mcs_do <= {4'h8, ifa.mcs_a[3:0]};
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
  endtask

  typedef struct {
    int       cyc;
    logic     host;
    logic [7:0] data;
    logic     err;
  } rsp_t;
  rsp_t sbq [$];

  // Every valid pulse must match the response expected for exactly this cycle
  always @(negedge phi2) begin
    if (sbq.size() != 0 && sbq[0].cyc == cyc) begin
      rsp_t e;
      e = sbq.pop_front();
      if (e.host) begin
        chk("host_rvalid", 32'(ifa.host_rvalid), 32'(1'b1));
        chk("host_rdata",  32'(ifa.host_rdata),  32'(e.data));
        chk("host_rerr",   32'(ifa.host_rerr),   32'(e.err));
        chk("cpu_do_valid_cross", 32'(ifa.cpu_do_valid), 32'(1'b0));
      end else begin
        chk("cpu_do_valid", 32'(ifa.cpu_do_valid), 32'(1'b1));
        chk("cpu_do",       32'(ifa.cpu_do),       32'(e.data));
        chk("host_rvalid_cross", 32'(ifa.host_rvalid), 32'(1'b0));
      end
    end else if (ifa.cpu_do_valid === 1'b1 || ifa.host_rvalid === 1'b1) begin
      chk("stray_valid", 32'({ifa.cpu_do_valid, ifa.host_rvalid}), 32'(2'b00));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  task automatic next();
    @(posedge phi2);
    #1;
  endtask

  task automatic idle_a();
    ifa.cpu_req = 1'b0; ifa.cpu_we_n = 1'b1; ifa.cpu_rs0 = 1'b1; ifa.cpu_cs1 = 1'b1;
    ifa.cpu_a = 10'h000; ifa.cpu_di = 8'h00;
    ifa.host_req = 1'b0; ifa.host_we_n = 1'b1; ifa.host_rs0 = 1'b1; ifa.host_cs1 = 1'b1;
    ifa.host_a = 10'h000; ifa.host_di = 8'h00;
  endtask

  task automatic cpu_set(input logic we_n, input logic [9:0] a, input logic [7:0] di);
    ifa.cpu_req = 1'b1; ifa.cpu_we_n = we_n; ifa.cpu_rs0 = 1'b1; ifa.cpu_cs1 = 1'b0;
    ifa.cpu_a = a; ifa.cpu_di = di;
  endtask

  task automatic host_set(input logic we_n, input logic [9:0] a, input logic [7:0] di);
    ifa.host_req = 1'b1; ifa.host_we_n = we_n; ifa.host_rs0 = 1'b1; ifa.host_cs1 = 1'b0;
    ifa.host_a = a; ifa.host_di = di;
  endtask

  typedef struct {
    logic       cpu_req, host_req;
    logic       exp_rdy, exp_ack, exp_we_n, exp_rs0, exp_cs1;
    logic [9:0] exp_a;
    logic [7:0] exp_di;
  } vec_t;
  vec_t vt [7];

  initial begin
    // CPU writes 0xA5 to RAM 0x3C5, host writes 0x3C to I/O 0x340
    vt[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 10'h000, 8'h00};
    vt[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 10'h3C5, 8'hA5};
    vt[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 10'h340, 8'h3C};
    vt[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 10'h3C5, 8'hA5};
    vt[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 10'h3C5, 8'hA5};
    vt[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 10'h340, 8'h3C};
    vt[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 10'h000, 8'h00};

    idle_a();
    ifb.cpu_req = 1'b0; ifb.cpu_we_n = 1'b0; ifb.cpu_rs0 = 1'b1; ifb.cpu_cs1 = 1'b0;
    ifb.cpu_a = 10'h3C0; ifb.cpu_di = 8'h00;
    ifb.host_req = 1'b0; ifb.host_we_n = 1'b0; ifb.host_rs0 = 1'b1; ifb.host_cs1 = 1'b0;
    ifb.host_a = 10'h341; ifb.host_di = 8'h00;

    // Reset holds everything quiet even with both requesters asking
    next();
    cpu_set(1'b1, 10'h3C5, 8'h00);
    host_set(1'b1, 10'h340, 8'h00);
    #3;
    chk("rst_cpu_rdy",   32'(ifa.cpu_rdy),   32'(1'b0));
    chk("rst_host_ack",  32'(ifa.host_ack),  32'(1'b0));
    chk("rst_mcs_rs0",   32'(ifa.mcs_rs0),   32'(1'b1));
    chk("rst_mcs_cs1",   32'(ifa.mcs_cs1),   32'(1'b1));
    chk("rst_mcs_we_n",  32'(ifa.mcs_we_n),  32'(1'b1));
    chk("rst_mcs_a",     32'(ifa.mcs_a),     32'(10'h000));
    chk("rst_cpu_do",    32'(ifa.cpu_do),    32'(8'h00));
    chk("rst_host_rdata",32'(ifa.host_rdata),32'(8'h00));
    chk("rst_valids",    32'({ifa.cpu_do_valid, ifa.host_rvalid, ifa.host_rerr}), 32'(3'b000));
    next();
    idle_a();
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      next();
      idle_a();
      if (vt[i].cpu_req)  cpu_set(1'b0, 10'h3C5, 8'hA5);
      if (vt[i].host_req) host_set(1'b0, 10'h340, 8'h3C);
      #3;
      chk($sformatf("vec%0d_cpu_rdy", i),  32'(ifa.cpu_rdy),  32'(vt[i].exp_rdy));
      chk($sformatf("vec%0d_host_ack", i), 32'(ifa.host_ack), 32'(vt[i].exp_ack));
      chk($sformatf("vec%0d_mcs_a", i),    32'(ifa.mcs_a),    32'(vt[i].exp_a));
      chk($sformatf("vec%0d_mcs_ctl", i),  32'({ifa.mcs_we_n, ifa.mcs_rs0, ifa.mcs_cs1}),
          32'({vt[i].exp_we_n, vt[i].exp_rs0, vt[i].exp_cs1}));
      chk($sformatf("vec%0d_mcs_di", i),   32'(ifa.mcs_di),   32'(vt[i].exp_di));
    end

    // CPU RAM write then read back
    next(); idle_a(); cpu_set(1'b0, 10'h3C5, 8'hA5); #3;
    chk("cpuwr_rdy", 32'(ifa.cpu_rdy), 32'(1'b1));
    next(); idle_a(); cpu_set(1'b1, 10'h3C5, 8'h00);
    sbq.push_back('{cyc + 1, 1'b0, 8'hA5, 1'b0});
    #3;
    chk("cpurd_rdy", 32'(ifa.cpu_rdy), 32'(1'b1));
    next(); idle_a(); #3;
    chk("cpurd_rdy_after", 32'(ifa.cpu_rdy), 32'(1'b1));

    // Host-only reads: mapped I/O, then an unmapped address
    next(); idle_a(); host_set(1'b1, 10'h340, 8'h00);
    sbq.push_back('{cyc + 1, 1'b1, 8'h80, 1'b0});
    #3;
    chk("hostio_ack", 32'(ifa.host_ack), 32'(1'b1));
    next(); idle_a(); host_set(1'b1, 10'h000, 8'h00);
    sbq.push_back('{cyc + 1, 1'b1, 8'h00, 1'b1});
    #3;
    chk("hostun_ack", 32'(ifa.host_ack), 32'(1'b1));
    next(); idle_a(); #3;
    chk("host_idle_ack", 32'(ifa.host_ack), 32'(1'b0));

    // Starvation: CPU busy every cycle, host forced in at cycles 15 and 31
    for (int i = 0; i < 33; i++) begin
      next();
      cpu_set(1'b0, 10'h3F0, 8'h77);
      host_set(1'b0, 10'h341, 8'h99);
      #3;
      chk($sformatf("starve%0d_ack", i), 32'(ifa.host_ack), 32'(i == 15 || i == 31));
      chk($sformatf("starve%0d_rdy", i), 32'(ifa.cpu_rdy),  32'(!(i == 15 || i == 31)));
      chk($sformatf("starve%0d_a", i),   32'(ifa.mcs_a),
          32'((i == 15 || i == 31) ? 10'h341 : 10'h3F0));
    end
    next(); idle_a(); #3;

    // Alternating owners back to back, no cross-routing
    next(); idle_a(); cpu_set(1'b0, 10'h3C0, 8'h11); #3;
    next(); idle_a(); cpu_set(1'b0, 10'h3C1, 8'h22); #3;
    next(); idle_a(); cpu_set(1'b1, 10'h3C0, 8'h00);
    sbq.push_back('{cyc + 1, 1'b0, 8'h11, 1'b0});
    #3;
    next(); idle_a(); host_set(1'b1, 10'h3C1, 8'h00);
    sbq.push_back('{cyc + 1, 1'b1, 8'h22, 1'b0});
    #3;
    chk("alt_host_ack", 32'(ifa.host_ack), 32'(1'b1));
    next(); idle_a(); #3;
    chk("alt_cpu_do_hold", 32'(ifa.cpu_do), 32'(8'h11));
    next(); idle_a(); #3;
    chk("alt_host_rdata_hold", 32'(ifa.host_rdata), 32'(8'h22));

    // Reset right after a host read issue kills the response
    next(); idle_a(); host_set(1'b1, 10'h340, 8'h00); #3;
    chk("rstmid_ack", 32'(ifa.host_ack), 32'(1'b1));
    next(); idle_a(); rst = 1'b1; #3;
    chk("rstmid_rvalid", 32'(ifa.host_rvalid), 32'(1'b0));
    chk("rstmid_bus",    32'({ifa.mcs_rs0, ifa.mcs_cs1}), 32'(2'b11));
    chk("rstmid_rdy",    32'(ifa.cpu_rdy), 32'(1'b0));
    chk("rstmid_rdata",  32'(ifa.host_rdata), 32'(8'h00));
    for (int j = 0; j < 16; j++) begin
      next();
      rst = 1'b0;
      cpu_set(1'b0, 10'h3F0, 8'h55);
      host_set(1'b0, 10'h341, 8'h66);
      #3;
      chk($sformatf("postrst%0d_ack", j), 32'(ifa.host_ack), 32'(j == 15));
    end
    next(); idle_a(); #3;

    // Host withdraws at cycle 5, then reasserts; a fresh 15-cycle wait applies
    for (int j = 0; j < 22; j++) begin
      next();
      idle_a();
      cpu_set(1'b0, 10'h3F0, 8'h55);
      if (j != 5) host_set(1'b0, 10'h341, 8'h66);
      #3;
      chk($sformatf("withdraw%0d_ack", j), 32'(ifa.host_ack), 32'(j == 21));
    end
    next(); idle_a(); #3;

    // Zero starve limit: host wins on its first cycle
    next(); ifb.cpu_req = 1'b1; ifb.host_req = 1'b1; #3;
    chk("lim0_ack", 32'(ifb.host_ack), 32'(1'b1));
    chk("lim0_rdy", 32'(ifb.cpu_rdy),  32'(1'b0));
    chk("lim0_a",   32'(ifb.mcs_a),    32'(10'h341));
    next(); ifb.host_req = 1'b0; #3;
    chk("lim0_cpu_ack", 32'(ifb.host_ack), 32'(1'b0));
    chk("lim0_cpu_rdy", 32'(ifb.cpu_rdy),  32'(1'b1));
    chk("lim0_cpu_a",   32'(ifb.mcs_a),    32'(10'h3C0));
    next(); ifb.cpu_req = 1'b0;

    next(); next(); #3;
    chk("scoreboard_drained", 32'(sbq.size()), 32'(0));
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
